// File: rtl/project1_sequencer.sv
// Front-end controller for the Project1 four-operand core.
// Arbitrates two requesters round-robin, clears the core, loads A..D in
// operand order, waits for the core result under a timeout and returns
// the 9-bit result (or a timeout error) together with the requester ID.
module project1_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        core_reset,
  output logic        core_capture,
  output logic [1:0]  core_op,
  output logic [7:0]  core_d_in,
  input  logic [8:0]  core_result,
  input  logic        core_valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [8:0]  rsp_result,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_reg;
  logic            rr_pri_reg;
  logic            id_reg;
  logic [31:0]     data_reg;
  logic [1:0]      op_cnt_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            core_reset_reg;
  logic            core_capture_reg;
  logic [1:0]      core_op_reg;
  logic [7:0]      core_d_in_reg;
  logic            rsp_valid_reg;
  logic            rsp_id_reg;
  logic [8:0]      rsp_result_reg;
  logic            rsp_err_reg;

  logic            grant0;
  logic            grant1;
  logic [1:0]      op_next;
  logic [7:0]      op_bytes [4];

  // Operand byte for each op index: 0->A (MSB) .. 3->D (LSB)
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_op_bytes
      assign op_bytes[gi] = data_reg[31-8*gi -: 8];
    end
  endgenerate

  assign op_next = op_cnt_reg + 2'd1;

  // Grant only in IDLE; when both request, rr_pri picks the winner
  assign grant0 = (state_reg == S_IDLE) & req0_valid & (~req1_valid | ~rr_pri_reg);
  assign grant1 = (state_reg == S_IDLE) & req1_valid & (~req0_valid |  rr_pri_reg);

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  // Core is held in reset whenever the sequencer itself is in reset
  assign core_reset   = reset & core_reset_reg;
  assign core_capture = core_capture_reg;
  assign core_op      = core_op_reg;
  assign core_d_in    = core_d_in_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_id       = rsp_id_reg;
  assign rsp_result   = rsp_result_reg;
  assign rsp_err      = rsp_err_reg;
  assign busy         = (state_reg != S_IDLE);

  // Transaction FSM with registered core and response outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      rr_pri_reg       <= 1'b0;
      id_reg           <= 1'b0;
      data_reg         <= 32'd0;
      op_cnt_reg       <= 2'd0;
      to_cnt_reg       <= '0;
      core_reset_reg   <= 1'b1;
      core_capture_reg <= 1'b0;
      core_op_reg      <= 2'd0;
      core_d_in_reg    <= 8'd0;
      rsp_valid_reg    <= 1'b0;
      rsp_id_reg       <= 1'b0;
      rsp_result_reg   <= 9'd0;
      rsp_err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant0 | grant1) begin
            id_reg           <= grant1;
            data_reg         <= grant1 ? req1_data : req0_data;
            // Loser of a contested grant gets priority next time
            if (req0_valid & req1_valid) begin
              rr_pri_reg <= grant0;
            end
            core_reset_reg   <= 1'b0;
            core_capture_reg <= 1'b0;
            state_reg        <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          core_reset_reg   <= 1'b1;
          core_capture_reg <= 1'b1;
          op_cnt_reg       <= 2'd0;
          core_op_reg      <= 2'd0;
          core_d_in_reg    <= op_bytes[0];
          state_reg        <= S_LOAD;
        end
        S_LOAD: begin
          if (op_cnt_reg == 2'd3) begin
            // op and d_in keep their last values through WAIT
            core_capture_reg <= 1'b0;
            to_cnt_reg       <= '0;
            state_reg        <= S_WAIT;
          end else begin
            op_cnt_reg    <= op_next;
            core_op_reg   <= op_next;
            core_d_in_reg <= op_bytes[op_next];
          end
        end
        S_WAIT: begin
          // A valid result wins over a coincident timeout
          if (core_valid) begin
            rsp_result_reg <= core_result;
            rsp_err_reg    <= 1'b0;
            rsp_id_reg     <= id_reg;
            rsp_valid_reg  <= 1'b1;
            state_reg      <= S_DONE;
          end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
            rsp_result_reg <= 9'd0;
            rsp_err_reg    <= 1'b1;
            rsp_id_reg     <= id_reg;
            rsp_valid_reg  <= 1'b1;
            state_reg      <= S_DONE;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_project1_sequencer.sv
// Directed testbench for project1_sequencer with a behavioural core stub.
module tb_project1_sequencer;

  logic        clock;
  logic        reset;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        core_reset;
  logic        core_capture;
  logic [1:0]  core_op;
  logic [7:0]  core_d_in;
  logic [8:0]  core_result;
  logic        core_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [8:0]  rsp_result;
  logic        rsp_err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  project1_sequencer #(.TIMEOUT(16), .TO_W(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .core_reset   (core_reset),
    .core_capture (core_capture),
    .core_op      (core_op),
    .core_d_in    (core_d_in),
    .core_result  (core_result),
    .core_valid   (core_valid),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Core stub: latches operands under capture, raises valid stub_delay
  // cycles after capture falls; result is 1AB or the operand sum
  int         stub_delay = 3;
  bit         stub_never = 0;
  bit         stub_sum   = 0;
  logic [7:0] stub_ops [4];
  logic       stub_armed;
  int         stub_cnt;
  logic [9:0] stub_total;

  assign stub_total  = {2'b00, stub_ops[0]} + {2'b00, stub_ops[1]} +
                       {2'b00, stub_ops[2]} + {2'b00, stub_ops[3]};
  assign core_result = stub_sum ? stub_total[8:0] : 9'h1AB;

  always @(posedge clock or negedge core_reset) begin
    if (!core_reset) begin
      core_valid <= 1'b0;
      stub_armed <= 1'b0;
      stub_cnt   <= 0;
      for (int k = 0; k < 4; k++) stub_ops[k] <= 8'd0;
    end else if (core_capture) begin
      stub_ops[core_op] <= core_d_in;
      stub_armed        <= 1'b1;
      stub_cnt          <= 0;
      core_valid        <= 1'b0;
    end else if (stub_armed && !stub_never) begin
      if (stub_cnt == stub_delay - 1) begin
        core_valid <= 1'b1;
        stub_armed <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  // Drive a request from a negedge until accepted; returns at the CLEAR negedge
  task automatic send_req(input bit which, input logic [31:0] data, output bit ok);
    bit got;
    ok = 0;
    if (which) begin req1_valid = 1; req1_data = data; end
    else       begin req0_valid = 1; req0_data = data; end
    for (int i = 0; i < 40 && !ok; i++) begin
      #1 got = which ? req1_ready : req0_ready;
      @(posedge clock);
      if (got) ok = 1;
      @(negedge clock);
    end
    if (which) req1_valid = 0; else req0_valid = 0;
  endtask

  // Count negedges until rsp_valid is seen (bounded)
  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 64) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic do_handshake();
    rsp_ready = 1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    @(negedge clock);
    tests++; if (core_reset !== 1'b0) begin fails++; $display("FAIL reset_core_reset got %b exp 0", core_reset); end
    tests++; if (core_capture !== 1'b0 || core_op !== 2'd0 || core_d_in !== 8'd0) begin
      fails++; $display("FAIL reset_core_bus got cap=%b op=%0d d=%h exp 0/0/00", core_capture, core_op, core_d_in); end
    tests++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== 9'd0 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL reset_rsp got v=%b id=%b r=%h e=%b exp 0", rsp_valid, rsp_id, rsp_result, rsp_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1;
    @(negedge clock);
    tests++; if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_idle got busy=%b r0=%b r1=%b exp 0", busy, req0_ready, req1_ready); end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h01; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
    stub_delay = 3; stub_never = 0; stub_sum = 0;
    send_req(0, 32'h01000000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_accept got 0 exp 1"); end
    tests++; if (core_reset !== 1'b0 || core_capture !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_clear got crst=%b cap=%b busy=%b exp 0/0/1", core_reset, core_capture, busy); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      tests++;
      if (core_reset !== 1'b1 || core_capture !== 1'b1 || core_op !== 2'(i) || core_d_in !== exp_b[i]) begin
        fails++; $display("FAIL basic_load%0d got crst=%b cap=%b op=%0d d=%h exp 1/1/%0d/%h",
                          i, core_reset, core_capture, core_op, core_d_in, i, exp_b[i]);
      end
    end
    @(negedge clock);
    tests++; if (core_capture !== 1'b0 || core_op !== 2'd3 || core_d_in !== 8'h00) begin
      fails++; $display("FAIL basic_wait_hold got cap=%b op=%0d d=%h exp 0/3/00", core_capture, core_op, core_d_in); end
    wait_rsp(n);
    tests++; if (n !== 4) begin fails++; $display("FAIL basic_wait_cycles got %0d exp 4", n); end
    tests++; if (rsp_id !== 1'b0 || rsp_result !== 9'h1AB || rsp_err !== 1'b0) begin
      fails++; $display("FAIL basic_rsp got id=%b r=%h e=%b exp 0/1ab/0", rsp_id, rsp_result, rsp_err); end
    $display("[TB] basic txn id=%0d result=%h err=%0d", rsp_id, rsp_result, rsp_err);
    do_handshake();
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_release got v=%b busy=%b exp 0/0", rsp_valid, busy); end
  endtask

  task automatic test_arbitration();
    int n;
    stub_delay = 3; stub_never = 0; stub_sum = 0;
    req0_valid = 1; req0_data = 32'hFFFF0000;
    req1_valid = 1; req1_data = 32'hFFFFFFFF;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL arb_first got r0=%b r1=%b exp 1/0", req0_ready, req1_ready); end
    @(posedge clock);
    @(negedge clock);
    req0_valid = 0;
    wait_rsp(n);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 9'h1AB) begin
      fails++; $display("FAIL arb_rsp0 got v=%b id=%b r=%h exp 1/0/1ab", rsp_valid, rsp_id, rsp_result); end
    $display("[TB] arb txn id=%0d result=%h err=%0d", rsp_id, rsp_result, rsp_err);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 9'h1AB || rsp_err !== 1'b0 || req1_ready !== 1'b0) begin
        fails++; $display("FAIL done_hold%0d got v=%b id=%b r=%h e=%b r1=%b exp 1/0/1ab/0/0",
                          i, rsp_valid, rsp_id, rsp_result, rsp_err, req1_ready);
      end
    end
    do_handshake();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL done_release got %b exp 0", rsp_valid); end
    #1;
    tests++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL arb_second_ready got %b exp 1", req1_ready); end
    @(posedge clock);
    @(negedge clock);
    req1_valid = 0;
    wait_rsp(n);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 9'h1AB || rsp_err !== 1'b0) begin
      fails++; $display("FAIL arb_rsp1 got v=%b id=%b r=%h e=%b exp 1/1/1ab/0", rsp_valid, rsp_id, rsp_result, rsp_err); end
    $display("[TB] arb txn id=%0d result=%h err=%0d", rsp_id, rsp_result, rsp_err);
    do_handshake();
    // Priority has moved to requester 1; offer both, then withdraw before the edge
    req0_valid = 1; req1_valid = 1;
    #1;
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      fails++; $display("FAIL arb_rr got r0=%b r1=%b exp 0/1", req0_ready, req1_ready); end
    req0_valid = 0; req1_valid = 0;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    stub_never = 1;
    send_req(0, 32'h12345678, ok);
    repeat (5) @(negedge clock);
    wait_rsp(n);
    tests++; if (n !== 16) begin fails++; $display("FAIL timeout_cycles got %0d exp 16", n); end
    tests++; if (!ok || rsp_valid !== 1'b1 || rsp_result !== 9'd0 || rsp_err !== 1'b1 || rsp_id !== 1'b0) begin
      fails++; $display("FAIL timeout_rsp got v=%b id=%b r=%h e=%b exp 1/0/000/1", rsp_valid, rsp_id, rsp_result, rsp_err); end
    $display("[TB] timeout txn id=%0d result=%h err=%0d", rsp_id, rsp_result, rsp_err);
    do_handshake();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_idle got busy=%b exp 0", busy); end
    stub_never = 0;
  endtask

  task automatic test_valid_at_timeout();
    bit ok;
    int n;
    stub_delay = 15;
    send_req(1, 32'h0A0B0C0D, ok);
    repeat (5) @(negedge clock);
    wait_rsp(n);
    tests++; if (n !== 16 || rsp_err !== 1'b0 || rsp_result !== 9'h1AB || rsp_id !== 1'b1) begin
      fails++; $display("FAIL edge_valid got n=%0d id=%b r=%h e=%b exp 16/1/1ab/0", n, rsp_id, rsp_result, rsp_err); end
    $display("[TB] edge txn id=%0d result=%h err=%0d", rsp_id, rsp_result, rsp_err);
    do_handshake();
    stub_delay = 3;
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    int n;
    int seen;
    stub_delay = 3;
    send_req(0, 32'hAABBCCDD, ok);
    repeat (3) @(negedge clock);
    tests++; if (core_op !== 2'd2 || core_capture !== 1'b1) begin
      fails++; $display("FAIL midrst_pos got op=%0d cap=%b exp 2/1", core_op, core_capture); end
    reset = 0;
    #1;
    tests++; if (core_reset !== 1'b0 || core_capture !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_force got crst=%b cap=%b busy=%b v=%b exp 0/0/0/0", core_reset, core_capture, busy, rsp_valid); end
    @(negedge clock);
    reset = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_quiet got %0d active cycles exp 0", seen); end
    send_req(1, 32'hFF0000FE, ok);
    wait_rsp(n);
    tests++; if (!ok || rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 9'h1AB || rsp_err !== 1'b0) begin
      fails++; $display("FAIL midrst_after got v=%b id=%b r=%h e=%b exp 1/1/1ab/0", rsp_valid, rsp_id, rsp_result, rsp_err); end
    $display("[TB] post-reset txn id=%0d result=%h err=%0d", rsp_id, rsp_result, rsp_err);
    do_handshake();
  endtask

  task automatic test_core_vectors();
    bit ok;
    int n;
    logic [31:0] vec [2];
    logic [8:0]  exp_r [2];
    vec[0] = 32'h00000000; exp_r[0] = 9'h000;
    vec[1] = 32'hFFFFFFFE; exp_r[1] = 9'h1FB;
    stub_sum = 1;
    for (int i = 0; i < 2; i++) begin
      send_req(0, vec[i], ok);
      wait_rsp(n);
      tests++;
      if (!ok || rsp_valid !== 1'b1 || rsp_result !== exp_r[i] || rsp_err !== 1'b0) begin
        fails++; $display("FAIL core_vec%0d got v=%b r=%h e=%b exp 1/%h/0", i, rsp_valid, rsp_result, rsp_err, exp_r[i]);
      end
      $display("[TB] core txn data=%h result=%h err=%0d", vec[i], rsp_result, rsp_err);
      do_handshake();
    end
    stub_sum = 0;
  endtask

  initial begin
    reset = 0;
    req0_valid = 0; req0_data = 32'd0;
    req1_valid = 0; req1_data = 32'd0;
    rsp_ready = 0;
    repeat (2) @(negedge clock);
    test_reset();
    test_basic();
    test_arbitration();
    test_timeout();
    test_valid_at_timeout();
    test_reset_mid_load();
    test_core_vectors();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/project1_sequencer.md
Name: project1_sequencer

Overview:
Front-end controller for the Project1 four-operand core: ports capture, op[1:0], d_in[7:0], result[8:0] and valid.
- Arbitrates between two requesters, each offering a packed operand word {A,B,C,D}.
- Clears the core, loads the four operands in op order, waits for core valid under a timeout, then returns the 9-bit result with the requester ID.
- One core is shared. Only one transaction is in flight at a time.

Parameters:
TIMEOUT, 16, max cycles in WAIT before abort (>=1)
TO_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has operands
req0_data  in  32  {A[31:24],B[23:16],C[15:8],D[7:0]}
req0_ready  out  1  requester 0 accepted this cycle
req1_valid  in  1  requester 1 has operands
req1_data  in  32  same packing as req0_data
req1_ready  out  1  requester 1 accepted this cycle
core_reset  out  1  active-low reset to core
core_capture  out  1  core capture strobe
core_op  out  2  core operand select
core_d_in  out  8  core operand byte
core_result  in  9  core result
core_valid  in  1  core result valid
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued it
rsp_result  out  9  captured result (0 on timeout)
rsp_err  out  1  1 = timeout abort
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, CLEAR, LOAD, WAIT, DONE. All registers are 2-state; state encoding is free.
- Reset (reset=0, async), forced regardless of state including mid-transaction:
  - state=IDLE, rr_pri=0.
  - core_reset=0 combinationally while reset=0, so the core is also cleared.
  - core_capture=0, core_op=0, core_d_in=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0.
  - Any in-flight transaction is discarded and no response is issued.
- IDLE arbitration:
  - reqN_ready is combinational and asserted only in IDLE, for the grant winner only.
  - Only one valid: grant it.
  - Both valid: grant requester rr_pri. rr_pri is then set to the loser.
  - Handshake on reqN_valid&reqN_ready: latch data and ID, go to CLEAR.
- CLEAR, 1 cycle: core_reset=0, capture=0. Next state LOAD with op_cnt=0.
- LOAD, exactly 4 cycles:
  - core_reset=1, core_capture=1, core_op=op_cnt.
  - core_d_in is the latched byte for op_cnt: 0→A, 1→B, 2→C, 3→D.
  - op_cnt increments each cycle. After op_cnt=3, go to WAIT with timeout counter=0.
- WAIT:
  - core_capture=0; core_op and core_d_in hold their last values.
  - core_valid is sampled each edge, starting with the first WAIT cycle.
  - core_valid=1: latch core_result, rsp_err=0, go to DONE.
  - Otherwise the counter increments. At count==TIMEOUT-1 with no valid: rsp_result=0, rsp_err=1, go to DONE.
  - If valid and timeout coincide, valid wins.
- DONE:
  - rsp_valid=1. rsp_id, rsp_result and rsp_err are stable until handshake.
  - On rsp_valid&rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - Requests are not accepted in DONE (no bypass). Requests held by requesters are kept and granted from IDLE.
- Throughput and latency:
  - Minimum is 1 (IDLE accept) + 1 (CLEAR) + 4 (LOAD) + k (WAIT) + 1 (DONE) cycles per transaction.
  - rsp_valid rises on the edge at which core_valid was sampled.
- Requester data changing after acceptance has no effect.
- core_result is never passed through combinationally; it only appears via the registered rsp_result.

Test Plan:
- Stub core that asserts core_valid with result 9'h1AB three cycles after capture falls.
  - Stimulus: req0 {01,00,00,00}.
  - Expect: one cycle of core_reset=0, then op 0,1,2,3 with d_in 01,00,00,00 under capture=1, then rsp_valid with id=0, result=1AB, err=0.
- Both requesters valid in the same IDLE cycle: req0 {FF,FF,00,00}, req1 {FF,FF,FF,FF}.
  - Expect: req0 granted first (rr_pri=0); req1 granted after the first response handshakes.
  - Expect: rsp_id sequence 0 then 1.
- Stub never asserts valid.
  - Expect: WAIT lasts 16 cycles, then rsp_valid=1, result=000, err=1, then IDLE.
- rsp_ready held 0 for 5 cycles in DONE.
  - Expect: rsp fields stable, req1_ready=0 throughout, handshake on the cycle rsp_ready rises.
- Stimulus: reset asserted during LOAD at op=2.
  - Expect: immediately core_reset=0, capture=0, busy=0, state IDLE, no response.
  - Expect: a subsequent req1 {FF,00,00,FE} completes normally with id=1.
- Real Project1 core instantiated, vectors {00,00,00,00} and {FF,FF,FF,FE}.
  - Expect: rsp_result equals the core result observed when the core is driven directly with the same load sequence; err=0.
